// File: rtl/instruction_loader.sv
// Byte-stream program loader: assembles little-endian 32-bit words and writes them to
// sequential instruction-memory addresses 0..wordCount-1, holding the CPU meanwhile.
module instruction_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   wordCount,
  input  logic [7:0]            byteData,
  input  logic                  byteValid,
  output logic                  byteReady,
  output logic                  memWriteEnable,
  output logic [ADDR_WIDTH-1:0] memWriteAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  output logic                  busy,
  output logic                  cpuHold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   asm_q, asm_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;
  logic                    count_legal_s;
  logic                    last_word_s;

  assign count_legal_s = (wordCount != {(ADDR_WIDTH+1){1'b0}}) && (wordCount <= DEPTH);
  assign last_word_s   = ({1'b0, addr_q} == (count_q - CNT_ONE));

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (start && count_legal_s) begin
          count_d = wordCount;
          addr_d  = {ADDR_WIDTH{1'b0}};
          idx_d   = 2'd0;
          error_d = 1'b0;
          state_d = S_COLLECT;
        end else if (start) begin
          error_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (byteValid) begin
          asm_d[{idx_q, 3'b000} +: 8] = byteData;
          idx_d = idx_q + 2'd1;
          // The output word/address registers only change here, so they hold between writes
          if (idx_q == 2'd3) begin
            waddr_d = addr_q;
            wdata_d = asm_d;
            we_d    = 1'b1;
            state_d = S_WRITE;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_WRITE: begin
        if (last_word_s) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          idx_d   = 2'd0;
          state_d = S_COLLECT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      count_q <= {(ADDR_WIDTH+1){1'b0}};
      addr_q  <= {ADDR_WIDTH{1'b0}};
      idx_q   <= 2'd0;
      asm_q   <= {DATA_WIDTH{1'b0}};
      waddr_q <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  assign byteReady       = (state_q == S_COLLECT);
  assign memWriteEnable  = we_q;
  assign memWriteAddress = waddr_q;
  assign memWriteData    = wdata_q;
  assign busy            = busy_q;
  assign cpuHold         = busy_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule
